// File: rtl/fp_result_serializer.sv
// fp_result_serializer
//   Parallel-in, serial-out transmitter for FP adder results. A word is
//   captured on an accepted load and streamed LSB first, one bit per clock,
//   with wr_out qualifying each bit. hold_in pauses the frame without
//   consuming a bit. done_out pulses for one cycle after the last bit.
//
// Ports
//   clk_in       : clock, rising edge
//   rst_in       : asynchronous active-high reset
//   parallel_in  : word to transmit (sampled only on an accepted load)
//   load_in      : load request, accepted only while tx_rdy = 1
//   hold_in      : pause request, effective only while shifting
//   serial_out   : current data bit
//   wr_out       : strobe qualifying serial_out
//   tx_rdy       : idle and able to accept a load
//   done_out     : registered one-cycle end-of-frame pulse
module fp_result_serializer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_in,
    input  logic             hold_in,
    output logic             serial_out,
    output logic             wr_out,
    output logic             tx_rdy,
    output logic             done_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        tx_rdy     = 1'b0;
        wr_out     = 1'b0;
        serial_out = 1'b0;

        case (state_q)
            IDLE: begin
                tx_rdy = 1'b1;
                if (load_in) begin
                    sreg_d  = parallel_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // The pending bit stays on serial_out during a hold; only the
                // strobe is withdrawn so the receiver does not consume it.
                serial_out = sreg_q[0];
                wr_out     = ~hold_in;
                if (!hold_in) begin
                    sreg_d = sreg_q >> 1;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign done_out = done_q;

endmodule

// File: tb/tb_fp_result_serializer.sv
module tb_fp_result_serializer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         ld;
    logic         hd;
    logic [W-1:0] pin;
    logic         so, wo, rdy, dn;

    always #5 clk = ~clk;

    fp_result_serializer #(.WIDTH(W)) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .parallel_in(pin),
        .load_in    (ld),
        .hold_in    (hd),
        .serial_out (so),
        .wr_out     (wo),
        .tx_rdy     (rdy),
        .done_out   (dn)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: bits still to be sent, and the expected done pulse.
    bit           q[$];
    bit           done_m = 1'b0;
    logic [W-1:0] words[$];

    // Looped-back receiver: assembles strobed bits, LSB first.
    logic [W-1:0] rx_word = '0;
    int           rx_cnt = 0;

    // Per-scenario statistics.
    int wr_cnt, busy_cnt, done_cnt;
    logic held_bit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        wr_cnt = 0; busy_cnt = 0; done_cnt = 0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance
    // both the DUT and the model over the rising edge.
    task automatic step(input logic l, input logic h, input logic [W-1:0] p);
        bit busy;
        ld = l; hd = h; pin = p;
        #2;
        busy = (q.size() != 0);
        check("tx_rdy", {31'b0, rdy}, {31'b0, !busy});
        check("wr_out", {31'b0, wo}, {31'b0, busy && !h});
        check("serial_out", {31'b0, so}, {31'b0, busy ? q[0] : 1'b0});
        check("done_out", {31'b0, dn}, {31'b0, done_m});

        if (wo === 1'b1) begin
            wr_cnt++;
            rx_word = {so, rx_word[W-1:1]};
            rx_cnt++;
        end else if (rx_cnt == W) begin
            if (words.size() != 0) check("rx_word", rx_word, words.pop_front());
            else check("rx_unexpected", 32'd1, 32'd0);
            rx_cnt = 0;
        end
        if (rdy === 1'b0) busy_cnt++;
        if (dn === 1'b1) done_cnt++;

        if (busy) begin
            if (!h) begin
                void'(q.pop_front());
                done_m = (q.size() == 0);
            end else begin
                done_m = 1'b0;
            end
        end else begin
            done_m = 1'b0;
            if (l) begin
                for (int i = 0; i < W; i++) q.push_back(p[i]);
                words.push_back(p);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Reset asserted in the middle of a cycle; outputs must respond at once.
    task automatic mid_reset();
        ld = 1'b0; hd = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_tx_rdy", {31'b0, rdy}, 32'd1);
        check("rst_wr_out", {31'b0, wo}, 32'd0);
        check("rst_serial", {31'b0, so}, 32'd0);
        check("rst_done", {31'b0, dn}, 32'd0);
        q.delete();
        words.delete();
        done_m = 1'b0;
        rx_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ld = 1'b0; hd = 1'b0; pin = '0;
        clear_stats();
        #2;
        check("init_tx_rdy", {31'b0, rdy}, 32'd1);
        check("init_wr_out", {31'b0, wo}, 32'd0);
        check("init_done", {31'b0, dn}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'hFFFF_FFFF);   // hold ignored while idle

        // Bit order and frame latency.
        clear_stats();
        step(1'b1, 1'b0, 32'hABCD_1110);
        repeat (34) step(1'b0, 1'b0, 32'h5555_5555);
        check("order_wr_pulses", wr_cnt, 32);
        check("order_busy", busy_cnt, 32);
        check("order_done", done_cnt, 1);

        // Back-to-back frames with load held high.
        clear_stats();
        step(1'b1, 1'b0, 32'hAAAA_AAAA);
        repeat (33) step(1'b1, 1'b0, 32'hF891_23DE);
        repeat (34) step(1'b0, 1'b0, '0);
        check("b2b_wr_pulses", wr_cnt, 64);
        check("b2b_busy", busy_cnt, 64);
        check("b2b_done", done_cnt, 2);

        // Hold for three cycles after bit 5.
        clear_stats();
        step(1'b1, 1'b0, 32'h0000_0001);
        repeat (5) step(1'b0, 1'b0, '0);
        held_bit = so;
        repeat (3) begin
            step(1'b0, 1'b1, '0);
            check("hold_serial_stable", {31'b0, so}, {31'b0, held_bit});
        end
        repeat (30) step(1'b0, 1'b0, '0);
        check("hold_wr_pulses", wr_cnt, 32);
        check("hold_len", busy_cnt, 35);
        check("hold_done", done_cnt, 1);

        // Hold on the last-bit cycle delays the frame end.
        clear_stats();
        step(1'b1, 1'b0, 32'h8000_0003);
        repeat (31) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        repeat (3) step(1'b0, 1'b0, '0);
        check("lasthold_len", busy_cnt, 34);
        check("lasthold_done", done_cnt, 1);

        // Load while busy is dropped.
        clear_stats();
        step(1'b1, 1'b0, 32'h1234_5678);
        repeat (9) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 32'hFFFF_FFFF);
        repeat (26) step(1'b0, 1'b0, '0);
        check("busy_wr_pulses", wr_cnt, 32);
        check("busy_done", done_cnt, 1);

        // Reset mid-frame, then a zero word.
        step(1'b1, 1'b0, 32'hDEAD_BEEF);
        repeat (16) step(1'b0, 1'b0, '0);
        mid_reset();
        clear_stats();
        repeat (3) step(1'b0, 1'b0, '0);
        check("rst_no_resume", wr_cnt, 0);
        step(1'b1, 1'b0, 32'h0000_0000);
        repeat (34) step(1'b0, 1'b0, '0);
        check("zero_wr_pulses", wr_cnt, 32);
        check("zero_done", done_cnt, 1);

        // Randomised traffic.
        repeat (2500) step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom);
        repeat (3) begin
            step(1'b0, 1'b0, '0);
            while (q.size() != 0) step(1'b0, 1'b0, '0);
        end
        check("rand_words_drained", words.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_result_serializer.md
# fp_result_serializer

Parallel-in, serial-out transmitter for 32-bit floating-point words. Sits on the output side of the FP adder and streams each result one bit per clock, LSB first, with a write-enable strobe. It is the transmit end of the serial link whose receive end is `Shift_reg`. Wiring `serial_out`/`wr_out` of this block to `serial_in`/`wr_in` of `Shift_reg` must reproduce the loaded word on `Shift_reg`'s `parallel_out`.

## Interface
- `WIDTH`, default 32: word width in bits; the counter is `$clog2(WIDTH)` bits.
- `clk_in`, input, 1: sole clock; all state updates on the rising edge.
- `rst_in`, input, 1: asynchronous, active-high reset.
- `parallel_in`, input, WIDTH: word to transmit; sampled only on an accepted load.
- `load_in`, input, 1: load request; accepted at a rising edge only when `tx_rdy` = 1.
- `hold_in`, input, 1: pause request; freezes the frame while high during SHIFT.
- `serial_out`, output, 1: current data bit, LSB first.
- `wr_out`, output, 1: qualifies `serial_out`; high exactly once per transmitted bit.
- `tx_rdy`, output, 1: idle and able to accept a load.
- `done_out`, output, 1: one-cycle pulse after the last bit of a frame.

## Operation
- State machine has two states, IDLE and SHIFT, plus a WIDTH-bit shift register `sreg` and a bit counter `cnt`.
- **Reset values:**
  - `serial_out` = 0, `wr_out` = 0, `done_out` = 0, `tx_rdy` = 1.
  - State = IDLE, `cnt` = 0, `sreg` = 0.
- **IDLE:**
  - `tx_rdy` = 1, `wr_out` = 0, `serial_out` = 0.
  - If `load_in` = 1: `sreg` <= `parallel_in`, `cnt` <= 0, go to SHIFT.
  - `hold_in` is ignored in IDLE.
- **SHIFT, with `hold_in` = 0:**
  - `serial_out` = `sreg[0]`, `wr_out` = 1, `tx_rdy` = 0.
  - On each edge: `sreg` <= `sreg >> 1`, `cnt` <= `cnt` + 1.
  - When `cnt` = WIDTH-1: go to IDLE and assert `done_out` for the next cycle.
- **SHIFT, with `hold_in` = 1:**
  - `wr_out` = 0; `serial_out` keeps the pending bit.
  - `sreg` and `cnt` are frozen; no bit is consumed.
  - Any number of hold cycles is allowed, including consecutive ones.
- **Load while busy:** `load_in` with `tx_rdy` = 0 is ignored. The frame in progress is unaffected and the new word is dropped; the producer must wait for `tx_rdy`.
- **Data stability:** `parallel_in` may change freely after the load edge, because the word is captured into `sreg`.
- **Outputs:** `serial_out`, `wr_out` and `tx_rdy` are combinational decodes of state, `sreg[0]` and `hold_in`. `done_out` is registered.

## Timing
- **Load:** edge E0 accepts the load. Cycles 1..WIDTH after E0 (absent holds) carry `wr_out` = 1 and `serial_out` = `parallel_in[k-1]` in cycle k.
- **Frame latency:** WIDTH + 1 cycles from the load edge to `tx_rdy` returning high.
- **End of frame:** cycle WIDTH+1 has `wr_out` = 0, `tx_rdy` = 1 and `done_out` = 1, all in the same cycle.
- **Hold extends the frame:** each hold cycle adds exactly one cycle to the frame and produces no `wr_out` pulse.
- **Back-to-back frames:**
  - `load_in` held high continuously gives the next frame's first bit in cycle WIDTH+2.
  - This guarantees at least one `wr_out` = 0 cycle between frames, during which the receiver presents its word.
- **Simultaneous events:**
  - `hold_in` on the last-bit cycle delays frame end; `done_out` follows the actual last shift.
  - `load_in` in the `done_out` cycle is accepted, since `tx_rdy` = 1 in that cycle.
- **Reset mid-frame:** asynchronously forces `wr_out` = 0, `serial_out` = 0, `tx_rdy` = 1 and `done_out` = 0. The partial frame is abandoned and is not resumed after reset releases.
- **Counter wrap:** `cnt` never exceeds WIDTH-1; there is no wrap inside a frame.

## Test plan
- **Reset values:** assert `rst_in` mid-cycle → `tx_rdy` = 1 and `wr_out` = `serial_out` = `done_out` = 0 immediately, without waiting for a clock edge.
- **Bit order:** load 0xABCD1110 → in the 32 `wr_out` cycles, `serial_out` = 0,0,0,0,1,0,0,0,1,… (LSB first). Then `done_out` pulses once with `tx_rdy` = 1, and a looped-back `Shift_reg` shows `parallel_out` = 0xABCD1110.
- **Back-to-back frames:** hold `load_in` = 1 while sending 0xAAAAAAAA, then 0xF89123DE → exactly 32 `wr_out` pulses per frame with a single `wr_out` = 0 gap between them; the receiver captures both words.
- **Hold:**
  - Setup: load 0x00000001 and assert `hold_in` for 3 cycles after bit 5.
  - Response: 32 `wr_out` pulses total and frame length 35 cycles.
  - Response: `serial_out` stable during the hold.
  - Response: result 0x00000001.
- **Load while busy:** load 0x12345678, then pulse `load_in` with 0xFFFFFFFF at bit 10 → the transmitted word is still 0x12345678 and no second frame starts.
- **Reset mid-frame:** reset at bit 16 of 0xDEADBEEF, then release and load 0x00000000 → the abandoned frame does not resume, and exactly 32 zero bits are sent with `done_out` pulsing once.
